// File: rtl/uart_pkg.sv
// Shared UART types, defaults and helpers for the receiver and transmitter.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam int unsigned UART_OVERSAMPLE = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   // Clock cycles per oversample tick (integer division, rounds down).
   function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                 input int unsigned baud,
                                                 input int unsigned os);
      return clk_hz / (baud * os);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every TICK_DIV clocks, phase
// realignable through a synchronous clear.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned TICK_DIV = calc_tick_div(50_000_000, 115_200, UART_OVERSAMPLE)
)(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // Free-running divider; clear restarts the tick phase at zero.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop recovery, LSB first, with a
// valid/ready holding register and single-cycle framing/overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned BAUD        = 115_200,
   parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
   parameter int unsigned DATA_BITS   = UART_DATA_BITS
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned TICK_DIV = calc_tick_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
   localparam int unsigned SW       = $clog2(OVERSAMPLE);
   localparam int unsigned BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   rx_state_t            state;
   logic                 rx_m;
   logic                 rx_s;
   logic                 rx_d;
   logic                 start_edge;
   logic                 tick;
   logic [SW-1:0]        s_cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 byte_done;

   // Two-flop synchronizer plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   // A held-low line (break) never produces an edge, so it cannot retrigger.
   assign start_edge = (state == IDLE) && rx_d && !rx_s;

   uart_baud_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (start_edge),
      .tick  (tick)
   );

   // Frame recovery FSM: mid-bit sampling of start, data and stop bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         s_cnt     <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         byte_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         frame_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start_edge) begin
                  state <= START;
                  s_cnt <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (s_cnt == S_MID) begin
                     if (rx_s) begin
                        state <= IDLE;
                     end else begin
                        state   <= DATA;
                        s_cnt   <= '0;
                        bit_idx <= '0;
                     end
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (s_cnt == S_LAST) begin
                     shift[bit_idx] <= rx_s;
                     s_cnt          <= '0;
                     if (bit_idx == B_LAST) begin
                        bit_idx <= '0;
                        state   <= STOP;
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                     end
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               // Leaving at mid stop bit re-arms start detection half a bit early.
               if (tick) begin
                  if (s_cnt == S_LAST) begin
                     if (rx_s) begin
                        byte_done <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                     s_cnt <= '0;
                     state <= IDLE;
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

   // Holding register: load when empty or being drained, otherwise drop and flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (byte_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
